// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES key-expansion sequencer: one 128-bit round key per handshake.
// Define AES256_EN to add the key_256 port and the AES-256 schedule.
module AES_Sbox (
    input  logic [7:0] byte_val,
    output logic [7:0] sub_val
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign sub_val = SBOX[byte_val];
endmodule

module aes_key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef AES256_EN
    input  logic         key_256,
`endif
    input  logic [255:0] key_in,
    input  logic         round_key_ready,
    output logic         round_key_valid,
    output logic [127:0] round_key,
    output logic [3:0]   round_key_index,
    output logic         busy,
    output logic         done
);
`ifdef AES256_EN
    localparam int NW = 8;
`else
    localparam int NW = 4;
`endif

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] win_reg [NW];
    logic [31:0] win_next [NW];
    logic [7:0]  rcon_reg, rcon_next;
    logic [3:0]  index_reg, index_next;
    logic        done_reg, done_next;
    logic        mode_reg, mode_next;
    logic [3:0]  last_index;
    logic [31:0] sub_rot_in, sub_rot, sub_plain;
    logic [31:0] new_word [4];
    logic [31:0] temp;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

`ifdef AES256_EN
    logic [31:0] tail_word;
    // The last window word feeds both banks; AES-128 mode only uses words 0..3.
    assign tail_word  = mode_reg ? win_reg[7] : win_reg[3];
    assign sub_rot_in = {tail_word[23:0], tail_word[31:24]};
    assign last_index = mode_reg ? 4'd14 : 4'd10;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox_plain
            AES_Sbox u_sbox (.byte_val(win_reg[7][8*gi +: 8]), .sub_val(sub_plain[8*gi +: 8]));
        end
    endgenerate
`else
    logic unused_bits;
    assign unused_bits = ^key_in[127:0];
    assign sub_rot_in  = {win_reg[3][23:0], win_reg[3][31:24]};
    assign last_index  = 4'd10;
    assign sub_plain   = 32'h0;

    genvar gi;
`endif

    generate
        for (gi = 0; gi < 4; gi++) begin : g_sbox_rot
            AES_Sbox u_sbox (.byte_val(sub_rot_in[8*gi +: 8]), .sub_val(sub_rot[8*gi +: 8]));
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        win_next   = win_reg;
        rcon_next  = rcon_reg;
        index_next = index_reg;
        mode_next  = mode_reg;
        done_next  = 1'b0;

        // Odd AES-256 groups (i mod 8 == 4) take SubWord only, no rotation or Rcon.
        temp = sub_rot ^ {rcon_reg, 24'h0};
        if (mode_reg && index_reg[0]) begin
            temp = sub_plain;
        end
        new_word[0] = win_reg[0] ^ temp;
        for (int k = 1; k < 4; k++) begin
            new_word[k] = win_reg[k] ^ new_word[k-1];
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    for (int k = 0; k < NW; k++) begin
                        win_next[k] = key_in[255-32*k -: 32];
                    end
                    rcon_next  = 8'h01;
                    index_next = 4'd0;
`ifdef AES256_EN
                    mode_next  = key_256;
`endif
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (round_key_ready) begin
                    if (index_reg == last_index) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        index_next = index_reg + 4'd1;
                        if (mode_reg) begin
                            for (int k = 0; k < 4; k++) begin
                                win_next[k]           = win_reg[(k + 4) % NW];
                                win_next[(k + 4) % NW] = new_word[k];
                            end
                            if (!index_reg[0]) begin
                                rcon_next = xtime(rcon_reg);
                            end
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                win_next[k] = new_word[k];
                            end
                            rcon_next = xtime(rcon_reg);
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            for (int k = 0; k < NW; k++) begin
                win_reg[k] <= 32'h0;
            end
            rcon_reg  <= 8'h01;
            index_reg <= 4'd0;
            done_reg  <= 1'b0;
            mode_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            win_reg   <= win_next;
            rcon_reg  <= rcon_next;
            index_reg <= index_next;
            done_reg  <= done_next;
            mode_reg  <= mode_next;
        end
    end

    assign round_key_valid = (state_reg == EMIT);
    assign busy            = (state_reg == EMIT);
    assign round_key       = {win_reg[0], win_reg[1], win_reg[2], win_reg[3]};
    assign round_key_index = index_reg;
    assign done            = done_reg;
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Scoreboard bench for aes_key_schedule_ctrl; reference is a FIPS-197 style
// word-array expansion with a GF(2^8)-computed S-box.
module tb_aes_key_schedule_ctrl;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         key_256 = 1'b0;
    logic [255:0] key_in = '0;
    logic         round_key_ready = 1'b1;
    logic         round_key_valid;
    logic [127:0] round_key;
    logic [3:0]   round_key_index;
    logic         busy;
    logic         done;

    aes_key_schedule_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef AES256_EN
        .key_256(key_256),
`endif
        .key_in(key_in), .round_key_ready(round_key_ready),
        .round_key_valid(round_key_valid), .round_key(round_key),
        .round_key_index(round_key_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] key;
        logic [3:0]   idx;
        bit           last;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   done_due = 0;
    bit   rand_ready = 0;
    bit   hold_low = 0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 0 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic push_expected(input logic [255:0] key, input bit m);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = m ? 8 : 4;
        nr = m ? 14 : 10;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                rc = 8'h01;
                for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            sb.push_back('{key: {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, idx: 4'(r), last: (r == nr)});
        end
    endtask

    // Monitor: every valid cycle is checked against the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        tests++;
        if (done_due) begin
            if (!(done === 1'b1 && busy === 1'b0)) begin
                fails++;
                $display("FAIL done_pulse: done=%b busy=%b, required done=1 busy=0", done, busy);
            end
            done_due = 0;
        end else if (done !== 1'b0) begin
            fails++;
            $display("FAIL spurious_done: done=%b, required 0", done);
        end
        if (round_key_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_key: idx=%0d key=%h with empty scoreboard", round_key_index, round_key);
            end else begin
                e = sb[0];
                if (round_key !== e.key || round_key_index !== e.idx || busy !== 1'b1) begin
                    fails++;
                    $display("FAIL round_key: idx=%0d key=%h busy=%b, required idx=%0d key=%h busy=1",
                             round_key_index, round_key, busy, e.idx, e.key);
                end
                if (round_key_ready) begin
                    void'(sb.pop_front());
                    $display("[TB] accepted RK%0d %h", e.idx, e.key);
                    if (e.last) done_due = 1;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #2;
        round_key_ready = hold_low ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_valid"}, round_key_valid, 1'b0);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        tests++;
        if (round_key !== 128'h0 || round_key_index !== 4'h0) begin
            fails++;
            $display("FAIL %s_key: key=%h idx=%0d, required 0/0", tag, round_key, round_key_index);
        end
    endtask

    task automatic do_start(input logic [255:0] key, input bit m);
        push_expected(key, m);
        start   = 1'b1;
        key_in  = key;
        key_256 = m;
        tick();
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        check_bit("rk0_latency", round_key_valid, 1'b1);
    endtask

    task automatic wait_index(input logic [3:0] idx);
        int n = 0;
        while (round_key_index !== idx && n < 100) begin
            tick();
            n++;
        end
        check_bit("wait_index_timeout", round_key_index === idx, 1'b1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check_bit("wait_done_timeout", done, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        check_bit("drain_timeout", sb.size() == 0, 1'b1);
        tick();
        tick();
    endtask

    localparam logic [255:0] FIPS128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] FIPS256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin
        logic [255:0] k;
        bit m;
        repeat (2) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        $display("[TB] AES-128 known-answer key");
        do_start(FIPS128, 1'b0);
        drain();

        $display("[TB] backpressure at index 4");
        do_start(FIPS128, 1'b0);
        wait_index(4'd4);
        hold_low = 1;
        repeat (3) tick();
        hold_low = 0;
        drain();

        $display("[TB] start ignored while busy");
        k = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        do_start(k, 1'b0);
        wait_index(4'd6);
        start  = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        tick();
        start = 1'b0;
        drain();

        $display("[TB] reset mid-expansion");
        do_start({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0);
        wait_index(4'd3);
        rst = 1'b1;
        tick();
        sb.delete();
        done_due = 0;
        rst = 1'b0;
        check_reset_outputs("mid_reset");
        do_start(FIPS128, 1'b0);
        drain();

        $display("[TB] back-to-back start in done cycle");
        do_start({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0);
        wait_done();
        do_start({$urandom, $urandom, $urandom, $urandom, 128'h0}, 1'b0);
        drain();

`ifdef AES256_EN
        $display("[TB] AES-256 known-answer key");
        do_start(FIPS256, 1'b1);
        drain();
`endif

        $display("[TB] random keys with random ready");
        rand_ready = 1;
        for (int t = 0; t < 6; t++) begin
            m = 1'b0;
`ifdef AES256_EN
            m = $urandom_range(0, 1) == 1;
`endif
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (!m) k[127:0] = '0;
            do_start(k, m);
            drain();
        end
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
